// File: rtl/validator_arbiter.sv
// validator_arbiter: per-requester holding buffers feeding a single issue port
// through a round-robin arbiter, with a programmable minimum idle gap between
// issues and a saturating issue counter.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   i_req_valid         per-requester valid
//   i_req_data          per-requester transaction, requester p at [p*DATA_W +: DATA_W]
//   o_req_ready         per-requester ready (holding buffer empty)
//   i_enable            issue enable
//   i_min_gap           idle cycles forced after each issue (sampled at issue)
//   o_valid             single-cycle issue strobe
//   o_transaction       issued transaction (holds when idle)
//   o_grant_id          index of the issued requester (holds when idle)
//   o_issue_count       saturating count of issues
//   o_busy              any buffer full or gap still running
module validator_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_enable,
    input  logic [3:0]                i_min_gap,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_transaction,
    output logic [2:0]                o_grant_id,
    output logic [15:0]               o_issue_count,
    output logic                      o_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [3:0]  NUM_REQ_4 = 4'(NUM_REQ);

    localparam logic [0:0] StReady = 1'b0;
    localparam logic [0:0] StGap   = 1'b1;

    logic [NUM_REQ-1:0] buf_full_q, buf_full_d;
    logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
    logic [2:0]         last_grant_q;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [0:0]         state_q, state_d;

    logic               valid_q;
    logic [DATA_W-1:0]  txn_q;
    logic [2:0]         grant_q;
    logic [15:0]        count_q;

    logic               issue;
    logic               found;
    logic [3:0]         sum;
    logic [IDX_W-1:0]   win_idx;
    logic [2:0]         winner;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] clear;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found   = 1'b0;
        sum     = 4'd0;
        win_idx = '0;
        winner  = last_grant_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last_grant_q} + 4'(i);
            if (sum >= NUM_REQ_4) begin
                sum = sum - NUM_REQ_4;
            end
            if (!found && buf_full_q[sum[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = sum[IDX_W-1:0];
                winner  = sum[2:0];
            end
        end
    end

    assign issue = i_enable && (state_q == StReady) && (|buf_full_q);

    // A buffer being cleared this edge was full, so its ready is already low
    // and it cannot also accept on the same edge.
    assign accept = i_req_valid & ~buf_full_q;
    assign clear  = issue ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;

    assign buf_full_d = (buf_full_q | accept) & ~clear;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StReady: begin
                if (issue && (i_min_gap != 4'd0)) begin
                    gap_cnt_d = i_min_gap;
                    state_d   = StGap;
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q == 4'd1) begin
                    state_d = StReady;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full_q <= '0;
            for (int p = 0; p < int'(NUM_REQ); p++) begin
                buf_data_q[p] <= '0;
            end
        end else begin
            buf_full_q <= buf_full_d;
            for (int p = 0; p < int'(NUM_REQ); p++) begin
                if (accept[p]) begin
                    buf_data_q[p] <= i_req_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StReady;
            gap_cnt_q    <= 4'd0;
            last_grant_q <= 3'(NUM_REQ - 1);
            valid_q      <= 1'b0;
            txn_q        <= '0;
            grant_q      <= 3'd0;
            count_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= issue;
            if (issue) begin
                txn_q        <= buf_data_q[win_idx];
                grant_q      <= winner;
                last_grant_q <= winner;
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end
        end
    end

    assign o_req_ready   = ~buf_full_q;
    assign o_valid       = valid_q;
    assign o_transaction = txn_q;
    assign o_grant_id    = grant_q;
    assign o_issue_count = count_q;
    assign o_busy        = (|buf_full_q) || (gap_cnt_q != 4'd0);

endmodule

// File: tb/tb_validator_arbiter.sv
module tb_validator_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 128;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ*DATA_W-1:0] i_req_data;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic                      i_enable;
    logic [3:0]                i_min_gap;
    logic                      o_valid;
    logic [DATA_W-1:0]         o_transaction;
    logic [2:0]                o_grant_id;
    logic [15:0]               o_issue_count;
    logic                      o_busy;

    int total = 0;
    int bad   = 0;

    validator_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .o_req_ready  (o_req_ready),
        .i_enable     (i_enable),
        .i_min_gap    (i_min_gap),
        .o_valid      (o_valid),
        .o_transaction(o_transaction),
        .o_grant_id   (o_grant_id),
        .o_issue_count(o_issue_count),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] tags;     // {tag3, tag2, tag1, tag0}
        logic        en;
        logic [3:0]  gap;
        logic        exp_valid;
        logic [2:0]  exp_gid;
        logic [7:0]  exp_tag;
        logic [3:0]  exp_ready;
        logic        exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [DATA_W-1:0] pat(input logic [7:0] t);
        return {16{t}};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] tg, input logic en,
                                input logic [3:0] g, input logic ev, input logic [2:0] gid,
                                input logic [7:0] tag, input logic [3:0] rdy, input logic busy,
                                input logic [15:0] cnt);
        vec_t r;
        r.valid = v; r.tags = tg; r.en = en; r.gap = g;
        r.exp_valid = ev; r.exp_gid = gid; r.exp_tag = tag;
        r.exp_ready = rdy; r.exp_busy = busy; r.exp_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] tg, input logic en,
                         input logic [3:0] g);
        i_req_valid = v;
        for (int p = 0; p < NUM_REQ; p++) begin
            i_req_data[p*DATA_W +: DATA_W] = pat(tg[p*8 +: 8]);
        end
        i_enable  = en;
        i_min_gap = g;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " valid"}, DATA_W'(o_valid), '0);
        chk({tag, " txn"},   o_transaction, '0);
        chk({tag, " gid"},   DATA_W'(o_grant_id), '0);
        chk({tag, " cnt"},   DATA_W'(o_issue_count), '0);
        chk({tag, " ready"}, DATA_W'(o_req_ready), DATA_W'(4'b1111));
        chk({tag, " busy"},  DATA_W'(o_busy), '0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        drive(4'b0000, 32'h0, 1'b1, 4'd0);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;

        // valid, tags, en, gap | exp: valid, gid, tag, ready, busy, count
        // Round-robin from reset, then reload of ports 0 and 2.
        vecs.push_back(mk(4'b1111, 32'h13121110, 1, 0, 0, 0, 8'h00, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 0, 8'h10, 4'b0001, 1, 1));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 1, 8'h11, 4'b0011, 1, 2));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 2, 8'h12, 4'b0111, 1, 3));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 3, 8'h13, 4'b1111, 0, 4));
        vecs.push_back(mk(4'b0101, 32'h00220020, 1, 0, 0, 3, 8'h13, 4'b1010, 1, 4));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 0, 8'h20, 4'b1011, 1, 5));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 2, 8'h22, 4'b1111, 0, 6));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 0, 2, 8'h22, 4'b1111, 0, 6));
        // Accept on one port alongside issue from another; refuse on a full port.
        vecs.push_back(mk(4'b0011, 32'h00003130, 1, 0, 0, 2, 8'h22, 4'b1100, 1, 6));
        vecs.push_back(mk(4'b0011, 32'h00004140, 1, 0, 1, 0, 8'h30, 4'b1101, 1, 7));
        vecs.push_back(mk(4'b0011, 32'h00004140, 1, 0, 1, 1, 8'h31, 4'b1110, 1, 8));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 0, 8'h40, 4'b1111, 0, 9));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 0, 0, 8'h40, 4'b1111, 0, 9));
        // Gap of 3: issues 4 cycles apart, gap input dropped to 0 mid-gap.
        vecs.push_back(mk(4'b0011, 32'h00005150, 1, 3, 0, 0, 8'h40, 4'b1100, 1, 9));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 3, 1, 1, 8'h51, 4'b1110, 1, 10));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 0, 1, 8'h51, 4'b1110, 1, 10));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 0, 1, 8'h51, 4'b1110, 1, 10));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 0, 1, 8'h51, 4'b1110, 1, 10));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 0, 8'h50, 4'b1111, 0, 11));
        // Busy held by the gap alone.
        vecs.push_back(mk(4'b0001, 32'h00000060, 1, 2, 0, 0, 8'h50, 4'b1110, 1, 11));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 2, 1, 0, 8'h60, 4'b1111, 1, 12));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 0, 0, 8'h60, 4'b1111, 1, 12));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 0, 0, 8'h60, 4'b1111, 0, 12));
        // Enable low with three ports full, then resume from last_grant+1.
        vecs.push_back(mk(4'b1011, 32'h73007170, 0, 0, 0, 0, 8'h60, 4'b0100, 1, 12));
        vecs.push_back(mk(4'b0000, 32'h0,        0, 0, 0, 0, 8'h60, 4'b0100, 1, 12));
        vecs.push_back(mk(4'b0000, 32'h0,        0, 0, 0, 0, 8'h60, 4'b0100, 1, 12));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 1, 8'h71, 4'b0110, 1, 13));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 3, 8'h73, 4'b1110, 1, 14));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 0, 1, 0, 8'h70, 4'b1111, 0, 15));
        // Gap keeps counting down while disabled.
        vecs.push_back(mk(4'b0001, 32'h00000080, 1, 2, 0, 0, 8'h70, 4'b1110, 1, 15));
        vecs.push_back(mk(4'b0000, 32'h0,        1, 2, 1, 0, 8'h80, 4'b1111, 1, 16));
        vecs.push_back(mk(4'b0000, 32'h0,        0, 0, 0, 0, 8'h80, 4'b1111, 1, 16));
        vecs.push_back(mk(4'b0000, 32'h0,        0, 0, 0, 0, 8'h80, 4'b1111, 0, 16));

        foreach (vecs[k]) begin
            drive(vecs[k].valid, vecs[k].tags, vecs[k].en, vecs[k].gap);
            step();
            chk($sformatf("v%0d valid", k), DATA_W'(o_valid), DATA_W'(vecs[k].exp_valid));
            chk($sformatf("v%0d gid", k), DATA_W'(o_grant_id), DATA_W'(vecs[k].exp_gid));
            chk($sformatf("v%0d txn", k), o_transaction, pat(vecs[k].exp_tag));
            chk($sformatf("v%0d ready", k), DATA_W'(o_req_ready), DATA_W'(vecs[k].exp_ready));
            chk($sformatf("v%0d busy", k), DATA_W'(o_busy), DATA_W'(vecs[k].exp_busy));
            chk($sformatf("v%0d cnt", k), DATA_W'(o_issue_count), DATA_W'(vecs[k].exp_cnt));
        end

        // Reset mid-operation: two buffers full and gap_cnt=5.
        drive(4'b0111, 32'h00929190, 1'b1, 4'd5);
        step();
        drive(4'b0000, 32'h0, 1'b1, 4'd5);
        step();
        chk("mid pre valid", DATA_W'(o_valid), DATA_W'(1'b1));
        chk("mid pre gid", DATA_W'(o_grant_id), DATA_W'(3'd1));
        chk("mid pre ready", DATA_W'(o_req_ready), DATA_W'(4'b1010));
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        step();
        rst = 1'b1;
        drive(4'b0000, 32'h0, 1'b1, 4'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post rst idle%0d valid", k), DATA_W'(o_valid), '0);
            chk($sformatf("post rst idle%0d busy", k), DATA_W'(o_busy), '0);
        end
        drive(4'b1000, 32'h95000000, 1'b1, 4'd0);
        step();
        drive(4'b0000, 32'h0, 1'b1, 4'd0);
        step();
        chk("post rst issue valid", DATA_W'(o_valid), DATA_W'(1'b1));
        chk("post rst issue gid", DATA_W'(o_grant_id), DATA_W'(3'd3));
        chk("post rst issue txn", o_transaction, pat(8'h95));
        chk("post rst issue cnt", DATA_W'(o_issue_count), DATA_W'(16'd1));

        // Saturation: stream issues every cycle past 65535.
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive(4'b1111, 32'hA3A2A1A0, 1'b1, 4'd0);
        n = 0;
        for (int k = 0; k < 70000 && n < 65537; k++) begin
            step();
            if (o_valid) begin
                n++;
                if (n == 1 || n == 65534 || n == 65535 || n == 65536 || n == 65537) begin
                    chk($sformatf("sat cnt after %0d", n), DATA_W'(o_issue_count),
                        DATA_W'((n > 65535) ? 16'hFFFF : 16'(n)));
                end
            end
        end
        chk("sat issues reached", DATA_W'(n), DATA_W'(65537));
        drive(4'b0000, 32'h0, 1'b1, 4'd0);
        repeat (6) step();
        chk("sat final cnt", DATA_W'(o_issue_count), DATA_W'(16'hFFFF));
        chk("sat final busy", DATA_W'(o_busy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/validator_arbiter.md
VALIDATOR_ARBITER -- requirements
Module: validator_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports; legal values are 2..8.
REQ-002 SHALL have parameter DATA_W, default 128, meaning the transaction width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_req_valid, input, NUM_REQ bits: per-requester transaction valid.
REQ-006 SHALL have port i_req_data, input, NUM_REQ*DATA_W bits: per-requester transactions; requester p occupies bits [p*DATA_W +: DATA_W].
REQ-007 SHALL have port o_req_ready, output, NUM_REQ bits: per-requester ready.
REQ-008 SHALL have port i_enable, input, 1 bit: issue enable.
REQ-009 SHALL have port i_min_gap, input, 4 bits: minimum number of idle cycles between issues.
REQ-010 SHALL have port o_valid, output, 1 bit: issue strobe to the validator pipeline input.
REQ-011 SHALL have port o_transaction, output, DATA_W bits: the issued transaction.
REQ-012 SHALL have port o_grant_id, output, 3 bits: index of the issued requester, qualified by o_valid.
REQ-013 SHALL have port o_issue_count, output, 16 bits: total number of issues.
REQ-014 SHALL have port o_busy, output, 1 bit: any work pending.

Function
REQ-015 SHALL provide one holding buffer per requester; o_req_ready[p] = buffer p empty; a transfer occurs on an edge where i_req_valid[p] and o_req_ready[p] are both 1.
REQ-016 SHALL load the buffer with i_req_data slice p on transfer; the buffer is then full and o_req_ready[p]=0 from the next cycle.
REQ-017 SHALL issue when i_enable=1, gap_cnt=0 and at least one buffer is full; on that edge: o_valid=1, o_transaction=winner data, o_grant_id=winner index, winner buffer cleared.
REQ-018 SHALL register o_valid as a single-cycle pulse; with no issue, o_valid=0 and o_transaction and o_grant_id hold their last values.
REQ-019 SHALL select the winner round-robin: search from last_grant+1 upward with modulo NUM_REQ wrap; the first full buffer wins; last_grant updates to the winner.
REQ-020 SHALL have a latency of 1 edge from buffer load to earliest issue, i.e. a request accepted on edge E appears on o_valid in the cycle after edge E+1.
REQ-021 SHALL refuse a new transfer into a buffer on the same edge it is cleared by issue; per-port throughput is 1 per 2 cycles, aggregate throughput is 1 per cycle.
REQ-022 SHALL operate a 2-state FSM: READY (gap_cnt=0), GAP (gap_cnt>0).
REQ-023 SHALL, on issue with i_min_gap=G>0, load gap_cnt=G and move to GAP; with G=0 it stays in READY, giving back-to-back issue.
REQ-024 SHALL, in GAP, decrement gap_cnt each cycle and return to READY on the edge where it reaches 0; the next issue is thus no earlier than edge E+G+1.
REQ-025 SHALL sample i_min_gap only at issue; changes during GAP have no effect.
REQ-026 SHALL, while i_enable=0: issue nothing, keep accepting into empty buffers, keep counting down gap_cnt, and hold last_grant.
REQ-027 SHALL increment o_issue_count by 1 per issue, saturating at 0xFFFF.
REQ-028 SHALL drive o_busy combinationally as (any buffer full) OR (gap_cnt != 0).
REQ-029 SHALL allow an accept on port q to coincide with an issue from port p≠q, with both taking effect.

Reset
REQ-030 SHALL, while rst=0, immediately force: all buffers empty (o_req_ready all 1s), o_valid=0, o_transaction=0, o_grant_id=0, o_issue_count=0, gap_cnt=0, state READY, last_grant=NUM_REQ-1 (so port 0 has first priority).
REQ-031 SHALL discard in-flight buffered transactions on reset assertion mid-operation; the first issue after deassertion comes only from requests accepted after reset.

Verification
REQ-032 Single request: port 2 presents 0xA5 at edge 1, gap 0 -> o_valid=1 for one cycle after edge 2, o_grant_id=2, o_transaction=0xA5, count=1.
REQ-033 Round-robin: all 4 ports hold requests, gap 0 -> grants 0,1,2,3 on consecutive cycles; reloading port 0 and port 2 then gives grants 0,2.
REQ-034 Throttle: i_min_gap=3, ports 0 and 1 full -> issues exactly 4 cycles apart; changing i_min_gap to 0 mid-gap does not shorten that gap.
REQ-035 Enable: i_enable=0 with 3 ports full -> no o_valid, o_busy=1, o_req_ready=0 for those ports; on enabling, issues resume from last_grant+1.
REQ-036 Saturation: force 65537 issues -> o_issue_count remains 0xFFFF.
REQ-037 Reset mid-operation: pull rst low with 2 buffers full and gap_cnt=5 -> all outputs at reset values in that cycle; no issue after release until new requests arrive.
